// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out frame transmitter: start(0), DATA_W bits LSB first, optional parity, stop(1).
// Compile with PISO_TX_PARITY_EN defined to insert an even-parity bit between the data bits and stop.
module piso_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [DATA_W-1:0] din,
  input  logic              load,
  output logic              ready,
  output logic              sout,
  output logic              soutbar,
  output logic              busy,
  output logic              done
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_W - 1);

`ifdef PISO_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [IW-1:0]     idx, idx_n;
  logic [DATA_W-1:0] shreg, shreg_n;
  logic              bit_end;
  logic              sout_n, done_n, ready_n;
`ifdef PISO_TX_PARITY_EN
  logic              par_q, par_n;
`endif

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shreg_n = shreg;
    bit_end = (cnt == LAST_CNT);
`ifdef PISO_TX_PARITY_EN
    par_n   = par_q;
`endif
    case (state)
      IDLE: begin
        if (load) begin
          state_n = START;
          cnt_n   = '0;
          idx_n   = '0;
          shreg_n = din;
`ifdef PISO_TX_PARITY_EN
          par_n   = ^din;
`endif
        end
      end
      START: if (bit_end) state_n = DATA;
      DATA: begin
        if (bit_end) begin
          // shift on the boundary so shreg[0] is always the bit on the line
          shreg_n = shreg >> 1;
          if (idx == LAST_IDX) begin
`ifdef PISO_TX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end else begin
            idx_n = idx + 1'b1;
          end
        end
      end
`ifdef PISO_TX_PARITY_EN
      PARITY: if (bit_end) state_n = STOP;
`endif
      STOP: if (bit_end) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (state != IDLE) cnt_n = bit_end ? '0 : cnt + 1'b1;

    // outputs are registered from the next-state view so they change with the state
    sout_n = 1'b1;
    case (state_n)
      START:  sout_n = 1'b0;
      DATA:   sout_n = shreg_n[0];
`ifdef PISO_TX_PARITY_EN
      PARITY: sout_n = par_n;
`endif
      default: sout_n = 1'b1;
    endcase
    done_n  = (state_n == STOP) && (cnt_n == LAST_CNT);
    ready_n = (state_n == IDLE);
  end

  always_ff @(negedge clk) begin
    if (clr) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      shreg   <= '0;
      sout    <= 1'b1;
      soutbar <= 1'b0;
      ready   <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef PISO_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      idx     <= idx_n;
      shreg   <= shreg_n;
      sout    <= sout_n;
      soutbar <= ~sout_n;
      ready   <= ready_n;
      busy    <= ~ready_n;
      done    <= done_n;
`ifdef PISO_TX_PARITY_EN
      par_q   <= par_n;
`endif
    end
  end
endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: frame-position model compared every cycle on two instances (4 and 1 clks/bit), plus literal frames.
module tb_piso_tx;
  localparam int W  = 8;
  localparam int C0 = 4;
  localparam int C1 = 1;
`ifdef PISO_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]        clr, load, ready, sout, soutbar, busy, done;
  logic [1:0][W-1:0] din;

  piso_tx #(.DATA_W(W), .CLKS_PER_BIT(C0)) u0 (
    .clk(clk), .clr(clr[0]), .din(din[0]), .load(load[0]), .ready(ready[0]),
    .sout(sout[0]), .soutbar(soutbar[0]), .busy(busy[0]), .done(done[0]));
  piso_tx #(.DATA_W(W), .CLKS_PER_BIT(C1)) u1 (
    .clk(clk), .clr(clr[1]), .din(din[1]), .load(load[1]), .ready(ready[1]),
    .sout(sout[1]), .soutbar(soutbar[1]), .busy(busy[1]), .done(done[1]));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic a, input logic e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%b want=%b", nm, cyc, a, e);
    end
  endtask

  task automatic chki(input string nm, input int a, input int e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, a, e);
    end
  endtask

  // Model: a frame is just a position k within (W+2+PB)*cpb cycles; bit = k / cpb.
  logic         m_busy [2] = '{1'b0, 1'b0};
  int           m_k    [2] = '{0, 0};
  logic [W-1:0] m_word [2] = '{8'h00, 8'h00};

  function automatic int cpb(input int i);
    return (i == 0) ? C0 : C1;
  endfunction

  function automatic int flen(input int i);
    return (W + 2 + PB) * cpb(i);
  endfunction

  function automatic logic exp_sout(input int i);
    int b;
    if (!m_busy[i]) return 1'b1;
    b = m_k[i] / cpb(i);
    if (b == 0) return 1'b0;
    if (b <= W) return m_word[i][b-1];
    if (PB == 1 && b == W + 1) return ^m_word[i];
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (clr[i]) begin
        m_busy[i] <= 1'b0;
        m_k[i]    <= 0;
      end else if (!m_busy[i]) begin
        if (load[i]) begin
          m_busy[i] <= 1'b1;
          m_k[i]    <= 0;
          m_word[i] <= din[i];
        end
      end else if (m_k[i] == flen(i) - 1) begin
        m_busy[i] <= 1'b0;
      end else begin
        m_k[i] <= m_k[i] + 1;
      end
    end
  end

  always @(posedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("u%0d soutbar", i), soutbar[i], ~sout[i]);
        chk($sformatf("u%0d sout", i), sout[i], exp_sout(i));
        chk($sformatf("u%0d ready", i), ready[i], ~m_busy[i]);
        chk($sformatf("u%0d busy", i), busy[i], m_busy[i]);
        chk($sformatf("u%0d done", i), done[i], m_busy[i] && (m_k[i] == flen(i) - 1));
      end
    end
  end

  // Load w on u0 and compare each cycle against a hand-written frame (bit b of fbits = frame bit b).
  task automatic frame_lit(input logic [W-1:0] w, input logic [10:0] fbits, input int exp_len);
    @(posedge clk);
    load[0] = 1'b1;
    din[0]  = w;
    @(posedge clk);
    load[0] = 1'b0;
    din[0]  = ~w;
    chk("accept ready", ready[0], 1'b0);
    for (int n = 1; n <= exp_len + 1; n++) begin
      if (n > 1) @(posedge clk);
      if (n <= exp_len) begin
        chk($sformatf("lit sout n=%0d", n), sout[0], fbits[(n-1)/C0]);
        chk($sformatf("lit done n=%0d", n), done[0], n == exp_len);
        chk($sformatf("lit ready n=%0d", n), ready[0], 1'b0);
      end else begin
        chk("lit ready after done", ready[0], 1'b1);
      end
    end
  endtask

  initial begin
    int ones, dones, bb_len;
    logic [31:0] bb_sout, bb_done;
    clr  = 2'b11;
    load = 2'b00;
    din  = '0;
    repeat (2) @(posedge clk);
    clr = 2'b00;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst u%0d sout", i), sout[i], 1'b1);
      chk($sformatf("rst u%0d soutbar", i), soutbar[i], 1'b0);
      chk($sformatf("rst u%0d ready", i), ready[i], 1'b1);
      chk($sformatf("rst u%0d busy", i), busy[i], 1'b0);
      chk($sformatf("rst u%0d done", i), done[i], 1'b0);
    end
    chk_en = 1'b1;

`ifdef PISO_TX_PARITY_EN
    frame_lit(8'hA7, 11'b11101001110, 44);
    frame_lit(8'hA5, 11'b10101001010, 44);
`else
    frame_lit(8'hA5, 11'b01101001010, 40);
`endif
    repeat (2) @(posedge clk);

    // load during START must be dropped, not queued
    @(posedge clk); load[0] = 1'b1; din[0] = 8'h00;
    @(posedge clk); load[0] = 1'b0;
    @(posedge clk); load[0] = 1'b1; din[0] = 8'hFF;
    @(posedge clk); load[0] = 1'b0; din[0] = 8'h00;
    ones = 0;
    dones = 0;
    for (int n = 3; n <= 90; n++) begin
      if (n > 3) @(posedge clk);
      if (n <= 36 && sout[0]) ones++;
      if (done[0]) dones++;
    end
    chki("busy data ones", ones, 0);
    chki("busy frame count", dones, 1);

    // clr for 2 cycles mid-DATA with load high
    @(posedge clk); load[0] = 1'b1; din[0] = 8'h3C;
    @(posedge clk); load[0] = 1'b0;
    repeat (10) @(posedge clk);
    clr[0] = 1'b1; load[0] = 1'b1; din[0] = 8'hC3;
    @(posedge clk);
    chk("clr sout", sout[0], 1'b1);
    chk("clr soutbar", soutbar[0], 1'b0);
    chk("clr ready", ready[0], 1'b1);
    chk("clr busy", busy[0], 1'b0);
    chk("clr done", done[0], 1'b0);
    @(posedge clk);
    clr[0] = 1'b0; load[0] = 1'b0;
    dones = 0;
    for (int n = 0; n < 50; n++) begin
      @(posedge clk);
      if (done[0]) dones++;
    end
    chki("clr no done", dones, 0);

    // back-to-back on u1 (1 clk/bit), load held high
`ifdef PISO_TX_PARITY_EN
    bb_len  = 23;
    bb_sout = 32'b11100000000111000000010;
    bb_done = 32'b10000000000010000000000;
`else
    bb_len  = 21;
    bb_sout = 32'b110000000011000000010;
    bb_done = 32'b100000000001000000000;
`endif
    @(posedge clk); load[1] = 1'b1; din[1] = 8'h01;
    for (int n = 1; n <= bb_len; n++) begin
      @(posedge clk);
      if (n == 1) din[1] = 8'h80;
      if (n == bb_len) load[1] = 1'b0;
      chk($sformatf("b2b sout n=%0d", n), sout[1], bb_sout[n-1]);
      chk($sformatf("b2b done n=%0d", n), done[1], bb_done[n-1]);
    end
    repeat (4) @(posedge clk);
    chk("b2b idle after", ready[1], 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/piso_tx.md
PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8: number of data bits per frame (legal range 1..32).
REQ-002 The block SHALL have parameter CLKS_PER_BIT, default 4: clk cycles each serial bit is held (legal range 1..255).
REQ-003 The block SHALL have port clk, input, 1: single clock; all state updates on the falling edge of clk.
REQ-004 The block SHALL have port clr, input, 1: reset, synchronous and active-high.
REQ-005 The block SHALL have port din, input, DATA_W: parallel word to transmit.
REQ-006 The block SHALL have port load, input, 1: request to start a frame with din.
REQ-007 The block SHALL have port ready, output, 1: block idle and able to accept load.
REQ-008 The block SHALL have port sout, output, 1: serial line, idle high.
REQ-009 The block SHALL have port soutbar, output, 1: always the complement of sout.
REQ-010 The block SHALL have port busy, output, 1: frame in progress, equal to not ready.
REQ-011 The block SHALL have port done, output, 1: one-cycle pulse at the end of a frame.

Function
REQ-012 The block SHALL implement states IDLE, START, DATA, PARITY and STOP, with all outputs registered.
REQ-013 In IDLE the block SHALL drive sout=1, ready=1, busy=0 and done=0.
REQ-014 In IDLE, a falling edge with load=1 and clr=0 SHALL accept the frame: capture din into the shift register, clear the bit-cycle counter and enter START.
REQ-015 Acceptance SHALL take effect on the edge where load is sampled; sout=0 and ready=0 from that edge on.
REQ-016 START SHALL hold sout=0 for exactly CLKS_PER_BIT cycles.
REQ-017 DATA SHALL send the DATA_W bits LSB first, each held for CLKS_PER_BIT cycles, with a bit index counting 0..DATA_W-1.
REQ-018 Changes on din after acceptance SHALL NOT affect the frame in progress.
REQ-019 STOP SHALL hold sout=1 for CLKS_PER_BIT cycles; done SHALL be 1 only during the last STOP cycle, after which the block returns to IDLE.
REQ-020 Frame length SHALL be (DATA_W+2)*CLKS_PER_BIT cycles, plus CLKS_PER_BIT if parity is compiled in.
REQ-021 load asserted while busy SHALL be ignored and SHALL NOT be queued.
REQ-022 load held high continuously SHALL start a new frame on the first IDLE cycle after STOP (one idle-high cycle between frames).
REQ-023 With CLKS_PER_BIT=1, every state SHALL last exactly one cycle per bit.
REQ-024 The bit-cycle counter SHALL be at least ceil(log2(CLKS_PER_BIT+1)) bits wide and SHALL wrap to 0 at each bit boundary.

Reset
REQ-025 clr=1 at a falling edge SHALL force IDLE, sout=1, soutbar=0, ready=1, busy=0 and done=0, and SHALL clear the counters and shift register.
REQ-026 clr asserted mid-frame SHALL abort the frame with no done pulse; clr SHALL take priority over a simultaneous load.

Configuration
REQ-027 With macro PISO_TX_PARITY_EN defined, the block SHALL insert a PARITY state between DATA and STOP that sends even parity (XOR of the captured data bits) for CLKS_PER_BIT cycles.
REQ-028 Without PISO_TX_PARITY_EN, the block SHALL NOT contain the PARITY state or the parity logic, and DATA SHALL go directly to STOP.

Verification
REQ-029 Reset test: apply clr for 2 cycles during DATA with load=1 -> the next edge gives sout=1, ready=1 and no done pulse.
REQ-030 Single-frame test (DATA_W=8, CLKS_PER_BIT=4, no parity): load 0xA5 -> sout is 0,1,0,1,0,0,1,0,1,1 for 4 cycles each; done pulses at cycle 40; ready returns on the following edge.
REQ-031 Parity test (PISO_TX_PARITY_EN, load 0xA7) -> parity bit is 1 and the frame is 44 cycles long; load 0xA5 -> parity bit is 0.
REQ-032 Busy test: pulse load with 0xFF during START of a 0x00 frame -> all 8 data bits are 0 and exactly one frame is sent.
REQ-033 Back-to-back test (CLKS_PER_BIT=1, load held high, 0x01 then 0x80) -> two 10-cycle frames separated by one idle-high cycle.
REQ-034 Every test SHALL check that soutbar equals not sout on every cycle.
